soc_sram2wb: RTL and testbench
==============================

SOC_SRAM2WB -- requirements
Module: soc_sram2wb

Interface
REQ-001 SHALL have parameter DW, default 32, data width; legal values 32, 16, 8.
REQ-002 SHALL have parameter AW, default 32, byte address width.
REQ-003 SHALL have parameter LW, default 4, burst length field width, so bursts are up to 2^LW beats.
REQ-004 SHALL derive localparam SW = DW/8, the byte select width and byte increment per beat.
REQ-005 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-006 wb_rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 req_valid  in  1 / req_ready  out  1  request handshake; transfer when both are high.
REQ-008 req_we  in  1 (1=write) / req_addr  in  AW (byte address) / req_sel  in  SW / req_len  in  LW (beats minus 1).
REQ-009 wdat  in  DW / wdat_valid  in  1 / wdat_ready  out  1  write data stream, one word per beat.
REQ-010 rdat  out  DW / rdat_valid  out  1  read data stream, one word per beat.
REQ-011 done  out  1 / done_err  out  1  end-of-transaction pulse and its error flag.
REQ-012 wb_adr_o AW, wb_dat_o DW, wb_sel_o SW, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3, wb_bte_o 2  out  Wishbone B3 initiator.
REQ-013 wb_dat_i DW, wb_ack_i 1, wb_err_i 1, wb_rty_i 1  in  Wishbone responder returns.

Function
REQ-014 SHALL implement FSM states IDLE, BUS, RETRY, DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a handshake SHALL capture we, sel, len, and the address aligned down to SW bytes, then enter BUS next cycle.
REQ-016 In BUS, wb_cyc_o SHALL be 1; wb_stb_o = ~we | wdat_valid.
  - A write beat whose data is not yet valid SHALL deassert stb and hold cyc.
REQ-017 wb_we_o and wb_sel_o SHALL equal the captured values for the whole cycle; wb_dat_o SHALL equal wdat.
REQ-018 wb_bte_o SHALL be 2'b00 (linear).
REQ-019 wb_cti_o SHALL be:
  - 3'b000 when len = 0;
  - otherwise 3'b010 on every beat except the last, and 3'b111 on the last beat.
REQ-020 A beat completes on wb_ack_i & wb_stb_o.
  - wb_adr_o SHALL advance by SW, wrapping modulo 2^AW.
  - The beats-remaining counter SHALL decrement.
REQ-021 wdat_ready SHALL equal wb_ack_i & wb_stb_o & we, combinational.
REQ-022 On read ack, rdat and rdat_valid SHALL be registered, giving 1-cycle latency after ack; rdat_valid is a single-cycle pulse per beat.
REQ-023 On the last beat's ack, cyc and stb SHALL drop the next cycle and the FSM SHALL enter DONE.
REQ-024 wb_err_i & wb_stb_o SHALL abort the transaction.
  - cyc drops next cycle; enter DONE with done_err = 1.
  - No rdat_valid is produced for the erroring beat.
  - Remaining beats are discarded.
REQ-025 wb_rty_i & wb_stb_o SHALL enter RETRY.
  - cyc = 0 for exactly one cycle, then return to BUS at the same beat address and count.
  - cti SHALL be recomputed from the remaining count.
REQ-026 Priority on simultaneous responses SHALL be err > rty > ack.
REQ-027 DONE SHALL last one cycle and assert done = 1 (done_err per REQ-024), then enter IDLE.
  - A new request is accepted no earlier than the cycle after DONE.
REQ-028 Responses received while stb = 0 or cyc = 0 SHALL be ignored.

Reset
REQ-029 Asserting wb_rst_ni low SHALL force IDLE immediately, including mid-burst, and drive these outputs to their reset values:
  - wb_cyc_o, wb_stb_o, wb_we_o, rdat_valid, done, done_err = 0;
  - wb_cti_o = 3'b000, wb_bte_o = 2'b00;
  - wb_adr_o, wb_sel_o, rdat = 0;
  - req_ready = 1 once reset is released.
REQ-030 No partial transaction SHALL resume after reset release.

Verification
REQ-031 Single read: addr 0x100, len 0, ack 2 cycles after stb, wb_dat_i 0xDEADBEEF -> cti 000, rdat 0xDEADBEEF one cycle after ack, done = 1, done_err = 0.
REQ-032 Read burst: addr 0x1000, len 3, ack every cycle -> adr 0x1000/04/08/0C, cti 010,010,010,111, four rdat_valid pulses, done.
REQ-033 Write burst: len 1, wdat_valid low for 2 cycles mid-burst -> stb low while cyc stays high, exactly 2 wdat_ready pulses.
REQ-034 err on beat 2 of a 4-beat read -> cyc drops next cycle, 1 rdat_valid pulse, done_err = 1.
REQ-035 rty on beat 1, then ack -> 1 cycle with cyc low, beat reissued at same address, total beats = len+1.
REQ-036 Wrap and reset: addr 0xFFFFFFFC with len 1 -> second beat adr 0x00000000; reset asserted mid-burst -> cyc = 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/soc_sram2wb_if.sv
// soc_sram2wb_if: request-side and Wishbone-side signal bundles for the SRAM-to-Wishbone bridge
interface soc_sram2wb_req_if #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int LW = 4
);
   localparam int SW = DW / 8;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [SW-1:0] req_sel;
   logic [LW-1:0] req_len;
   logic [DW-1:0] wdat;
   logic          wdat_valid;
   logic          wdat_ready;
   logic [DW-1:0] rdat;
   logic          rdat_valid;
   logic          done;
   logic          done_err;
   modport master (
      output req_valid, req_we, req_addr, req_sel, req_len, wdat, wdat_valid,
      input  req_ready, wdat_ready, rdat, rdat_valid, done, done_err
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_sel, req_len, wdat, wdat_valid,
      output req_ready, wdat_ready, rdat, rdat_valid, done, done_err
   );
endinterface

interface soc_sram2wb_wb_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   localparam int SW = DW / 8;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic          wb_rty_i;
   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/soc_sram2wb.sv
// soc_sram2wb: turns burst requests with a word stream into Wishbone B3 incrementing bursts
module soc_sram2wb #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int LW = 4
) (
   input logic                  wb_clk_i,
   input logic                  wb_rst_ni,
   soc_sram2wb_req_if.slave     req,
   soc_sram2wb_wb_if.master     wb
);
   localparam int SW = DW / 8;
   typedef enum logic [1:0] {IDLE, BUS, RETRY, DONE} state_t;
   state_t        state, state_nx;
   logic          we_q;
   logic [SW-1:0] sel_q;
   logic [AW-1:0] adr_q;
   logic [LW-1:0] cnt_q;
   logic          single_q;
   logic          err_q;
   logic [DW-1:0] rdat_q;
   logic          rdat_valid_q;
   logic          stb;
   logic          hit_err;
   logic          hit_rty;
   logic          hit_ack;
   logic          last;
   assign stb     = (state == BUS) & (~we_q | req.wdat_valid);
   assign hit_err = stb & wb.wb_err_i;
   assign hit_rty = stb & wb.wb_rty_i & ~wb.wb_err_i;
   assign hit_ack = stb & wb.wb_ack_i & ~wb.wb_err_i & ~wb.wb_rty_i;
   assign last    = cnt_q == '0;
   // state register; reset aborts any burst in flight
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state <= IDLE;
      else            state <= state_nx;
   end
   // next state: error beats win over retry, retry over ack
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req.req_valid ? BUS : IDLE;
         BUS:     state_nx = (hit_err || (hit_ack && last)) ? DONE : hit_rty ? RETRY : BUS;
         RETRY:   state_nx = BUS;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // request capture, beat address/count tracking and registered read return
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         cnt_q        <= '0;
         single_q     <= 1'b0;
         err_q        <= 1'b0;
         rdat_q       <= '0;
         rdat_valid_q <= 1'b0;
      end else begin
         rdat_valid_q <= 1'b0;
         if (state == IDLE && req.req_valid) begin
            we_q     <= req.req_we;
            sel_q    <= req.req_sel;
            adr_q    <= req.req_addr & ~AW'(SW - 1);
            cnt_q    <= req.req_len;
            single_q <= req.req_len == '0;
            err_q    <= 1'b0;
         end
         if (hit_err) err_q <= 1'b1;
         if (hit_ack) begin
            adr_q <= adr_q + AW'(SW);
            cnt_q <= cnt_q - LW'(1);
         end
         if (hit_ack && !we_q) begin
            rdat_q       <= wb.wb_dat_i;
            rdat_valid_q <= 1'b1;
         end
      end
   end
   assign req.req_ready  = state == IDLE;
   assign req.wdat_ready = hit_ack & we_q;
   assign req.rdat       = rdat_q;
   assign req.rdat_valid = rdat_valid_q;
   assign req.done       = state == DONE;
   assign req.done_err   = (state == DONE) & err_q;
   assign wb.wb_adr_o    = adr_q;
   assign wb.wb_dat_o    = req.wdat;
   assign wb.wb_sel_o    = sel_q;
   assign wb.wb_we_o     = we_q;
   assign wb.wb_cyc_o    = state == BUS;
   assign wb.wb_stb_o    = stb;
   assign wb.wb_cti_o    = (state != BUS || single_q) ? 3'b000 : last ? 3'b111 : 3'b010;
   assign wb.wb_bte_o    = 2'b00;
endmodule

// File: tb/tb_soc_sram2wb.sv
// tb_soc_sram2wb: directed bursts against a scripted Wishbone responder with a queue scoreboard
module tb_soc_sram2wb;
   typedef struct {
      logic [31:0] adr;
      logic [2:0]  cti;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
   } beat_t;
   typedef struct {
      bit err;
      int acks;
      int gaps;
      int stalls;
      int wrs;
   } tx_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   soc_sram2wb_req_if #(.DW(32), .AW(32), .LW(4)) rq ();
   soc_sram2wb_wb_if  #(.DW(32), .AW(32))         wbi ();
   soc_sram2wb #(.DW(32), .AW(32), .LW(4)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .req       (rq),
      .wb        (wbi)
   );
   beat_t       bq[$];
   logic [31:0] rdq[$];
   tx_t         txq[$];
   int          vectors = 0;
   int          misses = 0;
   int          ack_delay = 0;
   int          err_beat = 0;
   int          rty_beat = 0;
   int          gap_idx = -1;
   int          gap_len = 0;
   int          w_last = -1;
   bit          expect_idle = 0;
   logic [31:0] wtab[16];
   logic [31:0] rd_tab[16];
   int          beat = 1;
   int          wcnt = 0;
   bit          rty_done = 0;
   int          widx = 0;
   int          gap_left = 0;
   bit          w_taken = 0;
   bit          busy = 0;
   bit          pending = 0;
   bit          prev_end = 0;
   int          tcnt = 0;
   int          n_done = 0;
   int          m_acks, m_gaps, m_stalls, m_wrs;
   beat_t       mb;
   tx_t         mt;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misses++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic void eb(input logic [31:0] a, input logic [2:0] c, input logic w,
                              input logic [3:0] s, input logic [31:0] d);
      beat_t b;
      b.adr = a; b.cti = c; b.we = w; b.sel = s; b.dat = d;
      bq.push_back(b);
   endfunction
   function automatic void et(input bit e, input int a, input int g, input int st, input int w);
      tx_t t;
      t.err = e; t.acks = a; t.gaps = g; t.stalls = st; t.wrs = w;
      txq.push_back(t);
   endfunction
   // scripted responder: waits ack_delay cycles of stb, then err/rty/ack per beat number
   always begin
      @(posedge clk);
      #3;
      wbi.wb_ack_i = 1'b0;
      wbi.wb_err_i = 1'b0;
      wbi.wb_rty_i = 1'b0;
      if (rq.req_valid && rq.req_ready) begin
         beat = 1;
         wcnt = 0;
         rty_done = 0;
      end else if (wbi.wb_cyc_o && wbi.wb_stb_o) begin
         if (wcnt < ack_delay) wcnt++;
         else begin
            wcnt = 0;
            if (beat == err_beat) wbi.wb_err_i = 1'b1;
            else if (beat == rty_beat && !rty_done) begin
               wbi.wb_rty_i = 1'b1;
               rty_done = 1;
            end else begin
               wbi.wb_ack_i = 1'b1;
               wbi.wb_dat_i = rd_tab[(beat - 1) % 16];
               beat++;
            end
         end
      end
   end
   // write data source with an optional hole after a chosen beat
   always begin
      @(posedge clk);
      #2;
      if (rq.req_valid && rq.req_ready) begin
         widx = 0;
         gap_left = 0;
      end else if (w_taken) begin
         widx++;
         if (widx == gap_idx) gap_left = gap_len;
      end
      if (gap_left > 0) begin
         rq.wdat_valid = 1'b0;
         gap_left--;
      end else rq.wdat_valid = widx <= w_last;
      rq.wdat = wtab[widx % 16];
   end
   // monitor: pops expectations whenever the DUT shows a response, read word or done
   always @(negedge clk) begin
      w_taken = rq.wdat_ready;
      if (!rst_n) begin
         chk("rst_cyc", 32'(wbi.wb_cyc_o), 0);
         chk("rst_stb", 32'(wbi.wb_stb_o), 0);
         chk("rst_we", 32'(wbi.wb_we_o), 0);
         chk("rst_cti", 32'(wbi.wb_cti_o), 0);
         chk("rst_bte", 32'(wbi.wb_bte_o), 0);
         chk("rst_adr", wbi.wb_adr_o, 0);
         chk("rst_sel", 32'(wbi.wb_sel_o), 0);
         chk("rst_rdat", rq.rdat, 0);
         chk("rst_rvalid", 32'(rq.rdat_valid), 0);
         chk("rst_done", 32'({rq.done, rq.done_err}), 0);
         busy = 0; pending = 0; prev_end = 0; tcnt = 0;
      end else begin
         if (expect_idle) begin
            chk("post_rst_cyc", 32'(wbi.wb_cyc_o), 0);
            chk("post_rst_ready", 32'(rq.req_ready), 1);
         end
         if (prev_end) chk("cyc_drop", 32'(wbi.wb_cyc_o), 0);
         prev_end = 0;
         if (pending || rq.rdat_valid) begin
            chk("rdat_latency", 32'(rq.rdat_valid), 32'(pending));
            if (rq.rdat_valid) begin
               if (rdq.size() == 0) chk("rdat_unexpected", 1, 0);
               else chk("rdat", rq.rdat, rdq.pop_front());
            end
         end
         pending = 0;
         if (busy) begin
            if (!wbi.wb_cyc_o && !rq.done) m_gaps++;
            if (wbi.wb_cyc_o && !wbi.wb_stb_o) m_stalls++;
            if (rq.wdat_ready) m_wrs++;
         end
         if (wbi.wb_cyc_o && wbi.wb_stb_o && (wbi.wb_ack_i || wbi.wb_err_i || wbi.wb_rty_i)) begin
            if (bq.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
               mb = bq.pop_front();
               chk("adr", wbi.wb_adr_o, mb.adr);
               chk("cti", 32'(wbi.wb_cti_o), 32'(mb.cti));
               chk("we_sel", 32'({wbi.wb_we_o, wbi.wb_sel_o, wbi.wb_bte_o}), 32'({mb.we, mb.sel, 2'b00}));
               if (mb.we) chk("wdat", wbi.wb_dat_o, mb.dat);
               if (wbi.wb_err_i) prev_end = 1;
               else if (wbi.wb_ack_i && !wbi.wb_rty_i) begin
                  m_acks++;
                  if (!mb.we) pending = 1;
                  if (mb.cti != 3'b010) prev_end = 1;
               end
            end
         end
         if (rq.done) begin
            if (txq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               mt = txq.pop_front();
               chk("done_err", 32'(rq.done_err), 32'(mt.err));
               chk("acks", m_acks, mt.acks);
               chk("cyc_gaps", m_gaps, mt.gaps);
               chk("stb_stalls", m_stalls, mt.stalls);
               chk("wdat_ready_pulses", m_wrs, mt.wrs);
               chk("beats_left", bq.size(), 0);
            end
            busy = 0;
            n_done++;
         end
         if (rq.req_valid && rq.req_ready) begin
            busy = 1; tcnt = 0;
            m_acks = 0; m_gaps = 0; m_stalls = 0; m_wrs = 0;
         end
         if (busy) begin
            tcnt++;
            if (tcnt > 500) begin
               chk("timeout", 1, 0);
               busy = 0;
               n_done++;
            end
         end
      end
   end
   task automatic cfg(input int ad, input int e, input int r);
      ack_delay = ad; err_beat = e; rty_beat = r;
      gap_idx = -1; gap_len = 0; w_last = -1;
   endtask
   task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] s,
                        input logic [3:0] l, input bit wait_done);
      int n0;
      n0 = n_done;
      @(posedge clk);
      #1;
      rq.req_valid = 1'b1; rq.req_we = we; rq.req_addr = a; rq.req_sel = s; rq.req_len = l;
      @(posedge clk);
      #1;
      rq.req_valid = 1'b0;
      if (wait_done) begin
         for (int i = 0; i < 1000 && n_done == n0; i++) @(posedge clk);
         if (n_done == n0) begin
            $display("FAIL wait_done: transaction never completed");
            $fatal(1, "bench stuck");
         end
      end
   endtask
   initial begin
      rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_addr = '0; rq.req_sel = '0; rq.req_len = '0;
      for (int i = 0; i < 16; i++) begin
         wtab[i] = 32'hA5A5_0001 + i;
         rd_tab[i] = 32'h1111_0000 + i;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cfg(2, 0, 0);
      rd_tab[0] = 32'hDEAD_BEEF;
      eb(32'h100, 3'b000, 0, 4'hF, 0);
      rdq.push_back(32'hDEAD_BEEF);
      et(0, 1, 0, 0, 0);
      issue(0, 32'h100, 4'hF, 0, 1);
      cfg(0, 0, 0);
      for (int i = 0; i < 4; i++) rd_tab[i] = 32'h1111_0000 + i;
      eb(32'h1000, 3'b010, 0, 4'hF, 0);
      eb(32'h1004, 3'b010, 0, 4'hF, 0);
      eb(32'h1008, 3'b010, 0, 4'hF, 0);
      eb(32'h100C, 3'b111, 0, 4'hF, 0);
      rdq.push_back(32'h1111_0000); rdq.push_back(32'h1111_0001);
      rdq.push_back(32'h1111_0002); rdq.push_back(32'h1111_0003);
      et(0, 4, 0, 0, 0);
      issue(0, 32'h1000, 4'hF, 3, 1);
      cfg(0, 0, 0);
      gap_idx = 1; gap_len = 2; w_last = 1;
      eb(32'h2000, 3'b010, 1, 4'h3, 32'hA5A5_0001);
      eb(32'h2004, 3'b111, 1, 4'h3, 32'hA5A5_0002);
      et(0, 2, 0, 2, 2);
      issue(1, 32'h2002, 4'h3, 1, 1);
      cfg(0, 2, 0);
      rd_tab[0] = 32'h3333_0001;
      eb(32'h300, 3'b010, 0, 4'hF, 0);
      eb(32'h304, 3'b010, 0, 4'hF, 0);
      rdq.push_back(32'h3333_0001);
      et(1, 1, 0, 0, 0);
      issue(0, 32'h300, 4'hF, 3, 1);
      cfg(0, 0, 1);
      rd_tab[0] = 32'h4444_0000; rd_tab[1] = 32'h4444_0001;
      eb(32'h400, 3'b010, 0, 4'hF, 0);
      eb(32'h400, 3'b010, 0, 4'hF, 0);
      eb(32'h404, 3'b111, 0, 4'hF, 0);
      rdq.push_back(32'h4444_0000); rdq.push_back(32'h4444_0001);
      et(0, 2, 1, 0, 0);
      issue(0, 32'h400, 4'hF, 1, 1);
      cfg(0, 0, 0);
      rd_tab[0] = 32'h5555_0000; rd_tab[1] = 32'h5555_0001;
      eb(32'hFFFF_FFFC, 3'b010, 0, 4'hF, 0);
      eb(32'h0000_0000, 3'b111, 0, 4'hF, 0);
      rdq.push_back(32'h5555_0000); rdq.push_back(32'h5555_0001);
      et(0, 2, 0, 0, 0);
      issue(0, 32'hFFFF_FFFC, 4'hF, 1, 1);
      cfg(1, 0, 0);
      w_last = 0;
      wtab[0] = 32'h0BAD_F00D;
      eb(32'h500, 3'b000, 1, 4'hF, 32'h0BAD_F00D);
      et(0, 1, 0, 0, 1);
      issue(1, 32'h500, 4'hF, 0, 1);
      cfg(5, 0, 0);
      issue(0, 32'h600, 4'hF, 3, 0);
      @(posedge clk);
      @(posedge clk);
      #4 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      expect_idle = 1;
      repeat (4) @(posedge clk);
      expect_idle = 0;
      cfg(0, 0, 0);
      rd_tab[0] = 32'h7777_7777;
      eb(32'h700, 3'b000, 0, 4'hF, 0);
      rdq.push_back(32'h7777_7777);
      et(0, 1, 0, 0, 0);
      issue(0, 32'h700, 4'hF, 0, 1);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
